// File: rtl/adc_serial_capture.sv
// adc_serial_capture: captures one MSB-first DDR serial word per conversion.
// Optional saturating frame error counter: define ADC_CAPTURE_ERRCNT_EN.
module adc_serial_capture #(
  parameter int DATA_BITS      = 18,
  parameter int CAPTURE_DELAY  = 2,
  parameter int TIMEOUT_CYCLES = 640
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cnv,
  input  logic                 adc_clk,
  input  logic                 sdo,
`ifdef ADC_CAPTURE_ERRCNT_EN
  input  logic                 err_count_clr,
  output logic [15:0]          err_count,
`endif
  output logic [DATA_BITS-1:0] sample_data,
  output logic                 sample_valid,
  output logic                 frame_err,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SHIFT
  } state_t;

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);
  localparam logic [31:0] TMO_MAX = 32'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic                 cnv_d;
  logic                 adc_clk_d;
  logic                 cnv_rise;
  logic                 clk_edge;
  logic                 strb;
  logic                 last_bit;
  logic                 tmo_hit;
  logic [CW-1:0]        bit_cnt;
  logic [31:0]          tmo;
  logic [DATA_BITS-2:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;

  // Previous-cycle copies of the generator strobes for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnv_d     <= 1'b0;
      adc_clk_d <= 1'b0;
    end else begin
      cnv_d     <= cnv;
      adc_clk_d <= adc_clk;
    end
  end

  assign cnv_rise = cnv & ~cnv_d;
  assign clk_edge = adc_clk ^ adc_clk_d;

  generate
    if (CAPTURE_DELAY == 0) begin : g_nodly
      assign strb = clk_edge;
    end else begin : g_dly
      logic [CAPTURE_DELAY-1:0] dly;

      // Delay the edge to line up with sdo after the ADC round trip
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dly <= '0;
        end else begin
          dly[0] <= clk_edge;
          for (int i = 1; i < CAPTURE_DELAY; i++) begin
            dly[i] <= dly[i-1];
          end
        end
      end

      assign strb = dly[CAPTURE_DELAY-1];
    end
  endgenerate

  assign shift_next = {shift_reg, sdo};
  assign last_bit   = strb && (bit_cnt == LAST);
  assign tmo_hit    = (tmo == TMO_MAX);

  // Frame FSM: completion beats abort, abort beats timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      tmo          <= '0;
      shift_reg    <= '0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cnv_rise) begin
            state   <= ARMED;
            bit_cnt <= '0;
            tmo     <= '0;
            busy    <= 1'b1;
          end
        end
        ARMED, SHIFT: begin
          if (last_bit) begin
            sample_data  <= shift_next;
            shift_reg    <= shift_next[DATA_BITS-2:0];
            sample_valid <= 1'b1;
            bit_cnt      <= '0;
            tmo          <= '0;
            if (cnv_rise) begin
              state <= ARMED;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (cnv_rise) begin
            frame_err <= 1'b1;
            state     <= ARMED;
            bit_cnt   <= '0;
            tmo       <= '0;
            busy      <= 1'b1;
          end else if (tmo_hit) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end else begin
            tmo <= tmo + 32'd1;
            if (strb) begin
              shift_reg <= shift_next[DATA_BITS-2:0];
              bit_cnt   <= bit_cnt + 1'b1;
              state     <= SHIFT;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADC_CAPTURE_ERRCNT_EN
  // Saturating count of frame error pulses; clear has priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (err_count_clr) begin
      err_count <= '0;
    end else if (frame_err && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
